clk_div_ctrl: RTL and testbench
===============================

// Module: clk_div_ctrl
// PURPOSE
//  Runtime controller for the integer clock divider: arbitrates ratio-change requests from N_REQ clients.
//  Applies the granted ratio to an internal programmable divider only at an output-period boundary,
//  so o_clk never glitches. It replaces the fixed-RATIO divider wherever software or other blocks
//  must retune a derived clock.
// PARAMETERS
//  N_REQ          2   number of requesting clients (>=1)
//  RATIO_W        8   width of a ratio value
//  DEFAULT_RATIO  9   ratio loaded at reset (>=2, < 2**RATIO_W)
// PORTS
//  i_clk    in   1              source clock; all logic on rising edge
//  i_rst    in   1              synchronous, active-high reset
//  i_req    in   N_REQ          per-client request; held high until that client's o_gnt
//  i_ratio  in   N_REQ*RATIO_W  requested ratio, client k at [k*RATIO_W +: RATIO_W]; stable while i_req[k]
//  o_gnt    out  N_REQ          one-hot, one-cycle completion pulse to the serviced client
//  o_err    out  1              one-cycle pulse, coincident with o_gnt, when the request was rejected
//  o_busy   out  1              high from grant decision until o_gnt (state != IDLE)
//  o_ratio  out  RATIO_W        ratio currently driving o_clk
//  o_tick   out  1              one-cycle pulse on the last i_clk cycle of each o_clk period
//  o_clk    out  1              divided clock, registered output
// BEHAVIOUR
//  Reset: o_ratio=DEFAULT_RATIO, cnt=0, o_clk=1, o_gnt=0, o_err=0, o_busy=0, o_tick=0, RR pointer=0, state=IDLE.
//  Divider: cnt counts 0..o_ratio-1 and wraps. o_clk is high while cnt < o_ratio/2 (floor), low otherwise.
//   Example: R=9 gives 4 high / 5 low; R=4 gives 2/2. o_tick is high when cnt==o_ratio-1.
//  FSM IDLE -> ARB -> PEND -> IDLE:
//   IDLE: if |i_req, go to ARB next cycle.
//   ARB: round-robin pick, starting at the pointer, of the first asserted i_req.
//    Latch its index and ratio; pointer <- winner+1 (mod N_REQ).
//    Ratio < 2: pulse o_gnt[w] and o_err in the next cycle, return to IDLE, o_ratio unchanged.
//    Ratio >= 2: go to PEND.
//   PEND: wait for o_tick. In that o_tick cycle, next o_ratio <- latched ratio and cnt wraps to 0.
//    o_gnt[w] pulses in the first cycle of the new period. Go to IDLE.
//  Latency: i_req rise to o_gnt is 2 cycles (reject) or 2 + cycles-to-period-end (accept). Max is 2 + old ratio.
//  Same ratio as current: serviced normally. o_clk waveform is unchanged.
//  Requests arriving or changing during ARB/PEND are not sampled until IDLE. The requester must not
//   drop i_req before o_gnt; dropping it is undefined for that client only.
//  A client re-asserting i_req the cycle after its o_gnt is a new request.
//  Reset mid-operation (any state): immediate return to reset values. The pending request is discarded
//   with no o_gnt, and o_clk restarts high at DEFAULT_RATIO.
//  o_clk never shows a high or low phase shorter than min(old,new) ratio/2 cycles. Ratio changes only at wrap.
// CONFIGURATION
//  `CLK_DIV_CTRL_GATE_EN defined: adds port i_gate (in, 1).
//   i_gate is sampled on o_tick. If 1, the next period is suppressed: o_clk held low, o_tick still pulses, cnt runs.
//   If 0 at an o_tick, normal output resumes from cnt=0. Ratio changes still apply on o_tick while gated.
//  Undefined: no i_gate port; o_clk free-running.
// STRUCTURE
//  Package clk_div_pkg: ctrl_state_t enum {IDLE, ARB, PEND}; localparam MIN_RATIO=2.
//   Also holds the function rr_pick(req, ptr) returning the winner index.
//  Sub-module clk_div_prog (inputs: i_clk, i_rst, ratio, load, gate; outputs: o_clk, o_tick, cnt).
//   It is a programmable counter divider and owns cnt and the duty rule. clk_div_ctrl holds the FSM and arbiter.
// TESTING
//  1 Release i_rst, no requests -> o_clk period 9 cycles (4 high/5 low), o_tick every 9th cycle, o_ratio=9.
//  2 req0 with ratio 4 raised at cnt=2 -> o_busy next cycle. Current period finishes at 9 cycles.
//    o_gnt=2'b01 on the first cycle of the new period, then period 4 (2/2).
//  3 req0=6 and req1=3 raised in the same cycle, pointer=0 -> req0 served first.
//    req1 then served at the following boundary; final o_ratio=3. Check pointer fairness by repeating with pointer=1.
//  4 req1 with ratio 1 -> 2 cycles later o_gnt=2'b10 with o_err=1. o_ratio and o_clk are undisturbed.
//  5 i_rst asserted in PEND (ratio 5 pending from ratio 9) -> no o_gnt, o_ratio=9, o_clk high, cnt=0 next cycle.
//  6 With `CLK_DIV_CTRL_GATE_EN, i_gate=1 at o_tick -> one full period of o_clk low.
//    Drop i_gate -> resumes high at cnt=0. Without the macro, the bench compiles with no i_gate port.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the runtime clock-divider controller.
//   ctrl_state_t : request-handling FSM states
//   MIN_RATIO    : smallest ratio the divider accepts
//   rr_pick      : round-robin winner search starting at a pointer
package clk_div_pkg;

  typedef enum logic [1:0] {IDLE, ARB, PEND} ctrl_state_t;

  localparam int unsigned MIN_RATIO = 2;
  // Upper bound on client count handled by rr_pick.
  localparam int unsigned MAX_REQ   = 32;

  // Returns the first asserted request at or after ptr, wrapping at n.
  // If nothing is asserted the pointer itself comes back; callers gate on |req.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] req,
                                          input int unsigned        ptr,
                                          input int unsigned        n);
    int unsigned w;
    int unsigned idx;
    logic        found;
    w     = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && |(req & (MAX_REQ'(1) << idx))) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider. Owns the period counter, the current
// ratio and the duty rule (high while cnt < ratio/2).
//   i_clk, i_rst : source clock, synchronous active-high reset
//   ratio        : ratio to adopt at the next wrap when load is high
//   load         : apply ratio at the next wrap
//   gate         : sampled at o_tick; 1 holds o_clk low for the next period
//   o_clk        : divided clock (flop output)
//   o_tick       : last source cycle of each output period
//   cnt          : period counter
//   o_ratio      : ratio currently in effect
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned RATIO_W       = 8,
  parameter int unsigned DEFAULT_RATIO = 9
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [RATIO_W-1:0] ratio,
  input  logic               load,
  input  logic               gate,
  output logic               o_clk,
  output logic               o_tick,
  output logic [RATIO_W-1:0] cnt,
  output logic [RATIO_W-1:0] o_ratio
);

  logic [RATIO_W-1:0] cnt_q, cnt_d, ratio_q, ratio_d;
  logic               clk_q, clk_d, gated_q, gated_d;

  assign o_tick  = (cnt_q == ratio_q - 1'b1);
  assign o_clk   = clk_q;
  assign cnt     = cnt_q;
  assign o_ratio = ratio_q;

  always_comb begin
    cnt_d   = o_tick ? '0 : cnt_q + 1'b1;
    ratio_d = (load && o_tick) ? ratio : ratio_q;
    gated_d = o_tick ? gate : gated_q;
    // Computed from next-state values so the flop lines up with cnt_q.
    clk_d   = !gated_d && (cnt_d < (ratio_d >> 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      ratio_q <= RATIO_W'(DEFAULT_RATIO);
      clk_q   <= 1'b1;
      gated_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      clk_q   <= clk_d;
      gated_q <= gated_d;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime controller for the integer clock divider. Round-robin arbitrates
// ratio-change requests and applies the winner only at a period boundary.
// Optional macro CLK_DIV_CTRL_GATE_EN adds i_gate (period suppression).
//   i_clk, i_rst : source clock, synchronous active-high reset
//   i_req        : per-client request, held until o_gnt
//   i_ratio      : client k ratio at [k*RATIO_W +: RATIO_W]
//   i_gate       : (macro only) suppress next o_clk period when high at o_tick
//   o_gnt        : one-hot completion pulse
//   o_err        : rejected-request flag, coincident with o_gnt
//   o_busy       : request in progress
//   o_ratio      : ratio driving o_clk
//   o_tick       : last source cycle of each o_clk period
//   o_clk        : divided clock
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned RATIO_W       = 8,
  parameter int unsigned DEFAULT_RATIO = 9
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*RATIO_W-1:0] i_ratio,
`ifdef CLK_DIV_CTRL_GATE_EN
  input  logic                     i_gate,
`endif
  output logic [N_REQ-1:0]         o_gnt,
  output logic                     o_err,
  output logic                     o_busy,
  output logic [RATIO_W-1:0]       o_ratio,
  output logic                     o_tick,
  output logic                     o_clk
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  ctrl_state_t        state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d, idx_q, idx_d, win;
  logic [RATIO_W-1:0] lat_q, lat_d, win_ratio, cnt;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               err_q, err_d, last, gate;

`ifdef CLK_DIV_CTRL_GATE_EN
  assign gate = i_gate;
`else
  assign gate = 1'b0;
`endif

  clk_div_prog #(
    .RATIO_W      (RATIO_W),
    .DEFAULT_RATIO(DEFAULT_RATIO)
  ) u_prog (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .ratio  (lat_q),
    .load   (state_q == PEND),
    .gate   (gate),
    .o_clk  (o_clk),
    .o_tick (o_tick),
    .cnt    (cnt),
    .o_ratio(o_ratio)
  );

  // Last cycle of the period, taken from the counter: the same instant the
  // divider adopts lat_q while we sit in PEND.
  assign last   = (cnt == o_ratio - 1'b1);
  assign o_gnt  = gnt_q;
  assign o_err  = err_q;
  assign o_busy = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    lat_d     = lat_q;
    gnt_d     = '0;
    err_d     = 1'b0;
    win       = PTR_W'(rr_pick(MAX_REQ'(i_req), 32'(ptr_q), N_REQ));
    win_ratio = i_ratio[win*RATIO_W +: RATIO_W];
    unique case (state_q)
      // The client granted this cycle still holds i_req; mask it so it is
      // not re-arbitrated.
      IDLE: if (|(i_req & ~gnt_q)) state_d = ARB;
      ARB: begin
        if (|i_req) begin
          idx_d = win;
          lat_d = win_ratio;
          ptr_d = (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
          if (win_ratio < RATIO_W'(MIN_RATIO)) begin
            gnt_d[win] = 1'b1;
            err_d      = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = PEND;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (last) begin
          gnt_d[idx_q] = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      lat_q   <= RATIO_W'(DEFAULT_RATIO);
      gnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized bench for clk_div_ctrl against a deadline-based reference model.
module tb_clk_div_ctrl;
  localparam int N = 2, W = 8, NCYC = 4000;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [N-1:0]     i_req;
  logic [N*W-1:0]   i_ratio;
`ifdef CLK_DIV_CTRL_GATE_EN
  logic             i_gate;
`endif
  logic [N-1:0]     o_gnt;
  logic             o_err, o_busy, o_tick, o_clk;
  logic [W-1:0]     o_ratio;

  clk_div_ctrl #(.N_REQ(N), .RATIO_W(W), .DEFAULT_RATIO(9)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_req  (i_req),
    .i_ratio(i_ratio),
`ifdef CLK_DIV_CTRL_GATE_EN
    .i_gate (i_gate),
`endif
    .o_gnt  (o_gnt),
    .o_err  (o_err),
    .o_busy (o_busy),
    .o_ratio(o_ratio),
    .o_tick (o_tick),
    .o_clk  (o_clk)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: output period as (ratio, phase), service as absolute
  // cycle deadlines for arbitration, commit and grant.
  int mR, mp, mgated, mptr;
  int svc, arb_at, gnt_at, commit_at, m_w, m_err, m_new;
  // Clients
  bit creq [N];
  bit cdone[N];
  int crat [N];

  task automatic model_reset();
    mR = 9; mp = 0; mgated = 0; mptr = 0;
    svc = 0; arb_at = -1; gnt_at = -1; commit_at = -1; m_w = 0; m_err = 0; m_new = 0;
  endtask

  initial begin
    int e_tick, e_clk, e_gnt, e_err, e_busy, rst_now, gate_v, reqv, w;
    i_rst = 1'b1; i_req = '0; i_ratio = '0;
`ifdef CLK_DIV_CTRL_GATE_EN
    i_gate = 1'b0;
`endif
    for (int k = 0; k < N; k++) begin creq[k] = 0; cdone[k] = 0; crat[k] = 0; end
    model_reset();
    gate_v = 0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge i_clk); #1;
      e_tick = (mp == mR - 1) ? 1 : 0;
      e_clk  = (mgated == 0 && mp < mR / 2) ? 1 : 0;
      e_gnt  = (svc != 0 && cyc == gnt_at) ? (1 << m_w) : 0;
      e_err  = (e_gnt != 0 && m_err != 0) ? 1 : 0;
      e_busy = (svc != 0 && cyc >= arb_at && (gnt_at < 0 || cyc < gnt_at)) ? 1 : 0;
      chk("o_clk",   32'(o_clk),   32'(e_clk));
      chk("o_tick",  32'(o_tick),  32'(e_tick));
      chk("o_ratio", 32'(o_ratio), 32'(mR));
      chk("o_gnt",   32'(o_gnt),   32'(e_gnt));
      chk("o_err",   32'(o_err),   32'(e_err));
      chk("o_busy",  32'(o_busy),  32'(e_busy));

      // Stimulus for this cycle; the first 30 cycles are request-free so the
      // reset-ratio waveform is observed on its own.
      rst_now = (cyc < 3 || $urandom_range(0, 199) == 0) ? 1 : 0;
      for (int k = 0; k < N; k++) begin
        if (rst_now != 0) begin
          creq[k] = 0; cdone[k] = 0;
        end else if (cdone[k]) begin
          cdone[k] = 0;
          if ($urandom_range(0, 1) == 1) begin creq[k] = 1; crat[k] = $urandom_range(0, 12); end
          else creq[k] = 0;
        end else if (e_gnt[k]) begin
          cdone[k] = 1;
        end else if (!creq[k] && cyc >= 30 && $urandom_range(0, 7) == 0) begin
          creq[k] = 1; crat[k] = $urandom_range(0, 12);
        end
      end
`ifdef CLK_DIV_CTRL_GATE_EN
      gate_v = ($urandom_range(0, 3) == 0) ? 1 : 0;
      i_gate = gate_v[0];
`endif
      i_rst = rst_now[0];
      reqv  = 0;
      for (int k = 0; k < N; k++) begin
        i_req[k] = creq[k];
        i_ratio[k*W +: W] = W'(crat[k]);
        if (creq[k]) reqv |= (1 << k);
      end

      // Advance the model to the next cycle.
      if (rst_now != 0) begin
        model_reset();
      end else begin
        if (svc != 0 && cyc == gnt_at) svc = 0;
        if (svc == 0) begin
          if ((reqv & ~e_gnt) != 0) begin svc = 1; arb_at = cyc + 1; gnt_at = -1; commit_at = -1; end
        end else if (cyc == arb_at) begin
          w = mptr;
          for (int i = N - 1; i >= 0; i--)
            if (reqv[(mptr + i) % N]) w = (mptr + i) % N;
          m_w = w; m_new = crat[w]; mptr = (w + 1) % N;
          if (m_new < 2) begin
            m_err = 1; gnt_at = cyc + 1;
          end else begin
            m_err = 0;
            commit_at = cyc + 1 + (mR - 1 - (mp + 1) % mR);
            gnt_at = commit_at + 1;
          end
        end
        if (e_tick != 0) begin
          if (svc != 0 && cyc == commit_at) mR = m_new;
          mp = 0;
          mgated = gate_v;
        end else begin
          mp++;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
